mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The port list SHALL begin: clk  in  1  single clock, all state on rising edge.
REQ-002 reset  in  1  synchronous, active-high; the polarity and synchronicity SHALL be exactly this.
REQ-003 ex_valid  in  1  EX stage presents an instruction this cycle.
REQ-004 ex_result  in  32  EX final result; ALU value or load/store address.
REQ-005 ex_store_data  in  32  store source register value.
REQ-006 ex_mem_read / ex_mem_write  in  1 each  load / store; both high is illegal and SHALL be treated as load.
REQ-007 ex_size  in  1  0=word, 1=byte.
REQ-008 ex_rd  in  4  destination register; ex_rf_le  in  1  register-file load enable.
REQ-009 mem_stall  out  1  hold EX/ID/IF; instruction not accepted this cycle.
REQ-010 dmem_req, dmem_we  out  1 each; dmem_addr  out  32; dmem_wdata  out  32; dmem_be  out  4.
REQ-011 dmem_rdata  in  32; dmem_ack  in  1  one-cycle completion pulse from data memory.
REQ-012 wb_valid  out  1; wb_data  out  32; wb_rd  out  4; wb_rf_le  out  1  registered WB-stage inputs.
REQ-013 forward_ex_mem  out  32  ex_result of the instruction held in this stage, for EX forwarding.
REQ-014 align_fault  out  1  one-cycle pulse, misaligned word access.

Function
REQ-015 States SHALL be IDLE and ACCESS only.
REQ-016 mem_stall SHALL equal (state==ACCESS) & !dmem_ack, combinationally.
REQ-017 On every rising edge with mem_stall=0, the stage SHALL capture all ex_* inputs into its holding register.
REQ-018 Captured ex_valid=0 SHALL yield wb_valid=0 next cycle (bubble), state IDLE.
REQ-019 Non-memory op: wb_valid=1, wb_data=ex_result, wb_rd, wb_rf_le SHALL appear one cycle after capture; state stays IDLE.
REQ-020 Aligned memory op (word with addr[1:0]==0, or any byte): state SHALL go to ACCESS; wb_valid=0 while in ACCESS.
REQ-021 In ACCESS, dmem_req=1 and dmem_addr/we/wdata/be SHALL be held stable until the cycle dmem_ack=1.
REQ-022 dmem_addr SHALL be {held_addr[31:2],2'b00}; dmem_we=1 for stores.
REQ-023 Word store: dmem_be=4'b1111, dmem_wdata=store data; byte store: dmem_be=1<<addr[1:0], byte replicated to all four lanes.
REQ-024 Word load: wb_data=dmem_rdata; byte load: lane addr[1:0] (little-endian) SHALL be zero-extended.
REQ-025 On the edge with dmem_ack=1 in ACCESS: wb_valid=1, wb_data per REQ-024 (stores: wb_rf_le=0), and a new EX instruction SHALL be captured on that same edge (back-to-back, zero dead cycles).
REQ-026 Memory latency SHALL be 1 + N cycles from capture to wb_valid, N = cycles until ack (N>=1).
REQ-027 Misaligned word access SHALL issue no dmem_req, pulse align_fault, produce wb_valid=1 with wb_rf_le=0, state stays IDLE.
REQ-028 dmem_ack while IDLE SHALL be ignored.
REQ-029 dmem_req SHALL be 0 in IDLE.

Reset
REQ-030 reset=1 on an edge SHALL force state=IDLE, wb_valid=0, wb_rf_le=0, wb_data=0, wb_rd=0, forward_ex_mem=0, align_fault=0, holding register valid=0.
REQ-031 Reset during ACCESS SHALL drop dmem_req the following cycle and discard the outstanding access; a later ack SHALL be ignored.
REQ-032 mem_stall SHALL be 0 in the cycle after reset.

Structure
REQ-033 Package mem_pkg SHALL hold state encoding (IDLE=0, ACCESS=1) and size codes (SIZE_WORD=0, SIZE_BYTE=1).
REQ-034 One combinational sub-module ls_align SHALL compute dmem_be, dmem_wdata lanes and load extraction/zero-extension; FSM and registers stay in mem_stage.

Verification
REQ-035 ALU op ex_result=0x0000_1234, rd=3, rf_le=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=3, mem_stall=0.
REQ-036 Word load addr 0x100, ack after 3 cycles with rdata 0xDEAD_BEEF -> mem_stall high 2 cycles, dmem_addr=0x100 stable, wb_data=0xDEADBEEF the cycle after ack.
REQ-037 Byte store addr 0x203, data 0x0000_00A5 -> dmem_be=4'b1000, dmem_wdata=0xA5A5_A5A5, dmem_we=1, dmem_addr=0x200, wb_rf_le=0.
REQ-038 Byte load addr 0x102, rdata 0x1122_3344 -> wb_data=0x0000_0022.
REQ-039 Word load addr 0x102 -> align_fault pulse, no dmem_req, wb_rf_le=0; then back-to-back load/ALU op with ack on first cycle -> ALU result wb_valid the cycle after load's wb_valid.
REQ-040 Reset asserted mid-ACCESS, then late ack -> dmem_req=0, wb_valid=0, state IDLE, ack ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory stage: FSM state encoding, access size codes, holding register layout.
// Latency: none (type and constant definitions only).
// Backpressure: none.
package mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;

    // Everything the stage keeps about the instruction it currently owns.
    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic [31:0] store_data;
        logic        mem_read;
        logic        mem_write;
        logic        size;
        logic [3:0]  rd;
        logic        rf_le;
    } hold_t;

    // A word access whose address is not 4-byte aligned never reaches data memory.
    function automatic logic word_misaligned(input logic is_mem, input logic size,
                                             input logic [1:0] addr_lo);
        return is_mem && (size == SIZE_WORD) && (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and data memory.
// Latency: none (wiring only).
// Backpressure: request stays asserted and stable until a one-cycle ack pulse.
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/ls_align.sv
// Byte-lane steering: store byte enables / lane replication and load lane extraction with zero-extension.
// Latency: purely combinational.
// Backpressure: none.
module ls_align
    import mem_pkg::*;
(
    input  logic        size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    // Byte accesses use one little-endian lane; word accesses use all four.
    always_comb begin
        be_o        = 4'b1111;
        wdata_o     = store_data_i;
        load_data_o = rdata_i;
        if (size_i == SIZE_BYTE) begin
            be_o        = 4'b0001 << addr_lo_i;
            wdata_o     = {4{store_data_i[7:0]}};
            load_data_o = {24'h000000, rdata_i[{addr_lo_i, 3'b000} +: 8]};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: holds one EX instruction, runs its data-memory access, feeds registered WB outputs.
// Latency: non-memory ops reach WB one cycle after capture; memory ops 1+N cycles (N = cycles to ack).
// Backpressure: mem_stall holds upstream while an access waits for ack; a new op is captured on the ack edge.
module mem_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_size,
    input  logic [3:0]  ex_rd,
    input  logic        ex_rf_le,
    output logic        mem_stall,
    mem_stage_if.master dmem,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [3:0]  wb_rd,
    output logic        wb_rf_le,
    output logic [31:0] forward_ex_mem,
    output logic        align_fault
);

    state_e      state_q, state_d;
    hold_t       hold_q, hold_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [3:0]  wb_rd_q, wb_rd_d;
    logic        wb_rf_le_q, wb_rf_le_d;
    logic        align_fault_q, align_fault_d;

    logic        hold_is_mem;
    logic        hold_is_load;
    logic        hold_misaligned;
    logic        ex_is_mem;
    logic        ex_needs_access;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;

    // Both read and write set is resolved as a load.
    assign hold_is_mem     = hold_q.mem_read | hold_q.mem_write;
    assign hold_is_load    = hold_q.mem_read;
    assign hold_misaligned = word_misaligned(hold_is_mem, hold_q.size, hold_q.result[1:0]);
    assign ex_is_mem       = ex_mem_read | ex_mem_write;
    assign ex_needs_access = ex_valid && ex_is_mem &&
                             !word_misaligned(ex_is_mem, ex_size, ex_result[1:0]);

    ls_align u_ls_align (
        .size_i       (hold_q.size),
        .addr_lo_i    (hold_q.result[1:0]),
        .store_data_i (hold_q.store_data),
        .rdata_i      (dmem.dmem_rdata),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .load_data_o  (load_data)
    );

    // Request fields come straight from the holding register, so they are stable for the whole access.
    assign mem_stall       = (state_q == ACCESS) && !dmem.dmem_ack;
    assign dmem.dmem_req   = (state_q == ACCESS);
    assign dmem.dmem_we    = hold_q.mem_write & ~hold_q.mem_read;
    assign dmem.dmem_addr  = {hold_q.result[31:2], 2'b00};
    assign dmem.dmem_be    = lane_be;
    assign dmem.dmem_wdata = lane_wdata;

    assign wb_valid        = wb_valid_q;
    assign wb_data         = wb_data_q;
    assign wb_rd           = wb_rd_q;
    assign wb_rf_le        = wb_rf_le_q;
    assign forward_ex_mem  = hold_q.result;
    assign align_fault     = align_fault_q;

    // Next state: retire the held op into WB, then refill the holding register whenever not stalled.
    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        wb_valid_d    = 1'b0;
        wb_data_d     = wb_data_q;
        wb_rd_d       = wb_rd_q;
        wb_rf_le_d    = 1'b0;
        align_fault_d = 1'b0;

        case (state_q)
            IDLE: begin
                // Held op is either a bubble, a non-memory op, or a faulting misaligned word access.
                if (hold_q.valid) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = hold_q.result;
                    wb_rd_d    = hold_q.rd;
                    if (hold_misaligned) begin
                        align_fault_d = 1'b1;
                    end else begin
                        wb_rf_le_d = hold_q.rf_le;
                    end
                end
            end
            ACCESS: begin
                if (dmem.dmem_ack) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = hold_q.rd;
                    if (hold_is_load) begin
                        wb_data_d  = load_data;
                        wb_rf_le_d = hold_q.rf_le;
                    end else begin
                        wb_data_d  = hold_q.result;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!mem_stall) begin
            hold_d.valid      = ex_valid;
            hold_d.result     = ex_result;
            hold_d.store_data = ex_store_data;
            hold_d.mem_read   = ex_mem_read;
            hold_d.mem_write  = ex_mem_write;
            hold_d.size       = ex_size;
            hold_d.rd         = ex_rd;
            hold_d.rf_le      = ex_rf_le;
            state_d           = ex_needs_access ? ACCESS : IDLE;
        end
    end

    // Registers; reset abandons any outstanding access so a later ack finds the stage idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= 32'h0;
            wb_rd_q       <= 4'h0;
            wb_rf_le_q    <= 1'b0;
            align_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            wb_valid_q    <= wb_valid_d;
            wb_data_q     <= wb_data_d;
            wb_rd_q       <= wb_rd_d;
            wb_rf_le_q    <= wb_rf_le_d;
            align_fault_q <= align_fault_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-op vectors plus hand sequences for back-to-back and reset cases.
// Latency: n/a.
// Backpressure: memory model acks after a per-vector cycle count.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_size;
    logic [3:0]  ex_rd;
    logic        ex_rf_le;
    logic        mem_stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [3:0]  wb_rd;
    logic        wb_rf_le;
    logic [31:0] forward_ex_mem;
    logic        align_fault;

    int total = 0;
    int bad   = 0;

    mem_stage_if dmem_bus ();

    mem_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_result      (ex_result),
        .ex_store_data  (ex_store_data),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_size        (ex_size),
        .ex_rd          (ex_rd),
        .ex_rf_le       (ex_rf_le),
        .mem_stall      (mem_stall),
        .dmem           (dmem_bus),
        .wb_valid       (wb_valid),
        .wb_data        (wb_data),
        .wb_rd          (wb_rd),
        .wb_rf_le       (wb_rf_le),
        .forward_ex_mem (forward_ex_mem),
        .align_fault    (align_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] sd;
        logic        rd_m;
        logic        wr_m;
        logic        size;
        logic [3:0]  rd;
        logic        rf_le;
        int          n;        // cycles in ACCESS until ack
        logic [31:0] rdata;
        logic        mem_exp;  // expect a dmem request
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_we;
        logic        chk_data;
        logic [31:0] e_data;
        logic        e_rf_le;
        logic        e_fault;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_valid      = 1'b0;
        ex_result     = 32'h0;
        ex_store_data = 32'h0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_size       = 1'b0;
        ex_rd         = 4'h0;
        ex_rf_le      = 1'b0;
    endtask

    task automatic drive_ex(input logic [31:0] res, input logic [31:0] sd, input logic rdm,
                            input logic wrm, input logic sz, input logic [3:0] rd, input logic le);
        ex_valid      = 1'b1;
        ex_result     = res;
        ex_store_data = sd;
        ex_mem_read   = rdm;
        ex_mem_write  = wrm;
        ex_size       = sz;
        ex_rd         = rd;
        ex_rf_le      = le;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        drive_ex(v.res, v.sd, v.rd_m, v.wr_m, v.size, v.rd, v.rf_le);
        dmem_bus.dmem_ack = 1'b0;
        @(negedge clk);
        ex_valid = 1'b0;
        if (v.mem_exp) begin
            for (int k = 1; k <= v.n; k++) begin
                chk($sformatf("v%0d_req_c%0d", idx, k), dmem_bus.dmem_req, 1);
                chk($sformatf("v%0d_addr_c%0d", idx, k), dmem_bus.dmem_addr, v.e_addr);
                chk($sformatf("v%0d_be_c%0d", idx, k), dmem_bus.dmem_be, v.e_be);
                chk($sformatf("v%0d_we_c%0d", idx, k), dmem_bus.dmem_we, v.e_we);
                if (v.e_we)
                    chk($sformatf("v%0d_wdata_c%0d", idx, k), dmem_bus.dmem_wdata, v.e_wdata);
                chk($sformatf("v%0d_fwd_c%0d", idx, k), forward_ex_mem, v.res);
                chk($sformatf("v%0d_wbv_busy_c%0d", idx, k), wb_valid, 0);
                if (k == v.n) begin
                    dmem_bus.dmem_ack   = 1'b1;
                    dmem_bus.dmem_rdata = v.rdata;
                end
                #1;
                chk($sformatf("v%0d_stall_c%0d", idx, k), mem_stall, (k == v.n) ? 0 : 1);
                @(negedge clk);
                dmem_bus.dmem_ack = 1'b0;
            end
        end else begin
            chk($sformatf("v%0d_noreq", idx), dmem_bus.dmem_req, 0);
            chk($sformatf("v%0d_nostall", idx), mem_stall, 0);
            @(negedge clk);
        end
        chk($sformatf("v%0d_wb_valid", idx), wb_valid, 1);
        chk($sformatf("v%0d_wb_rd", idx), wb_rd, v.rd);
        chk($sformatf("v%0d_wb_rf_le", idx), wb_rf_le, v.e_rf_le);
        chk($sformatf("v%0d_fault", idx), align_fault, v.e_fault);
        if (v.chk_data)
            chk($sformatf("v%0d_wb_data", idx), wb_data, v.e_data);
        chk($sformatf("v%0d_req_after", idx), dmem_bus.dmem_req, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        //          res           sd            rd wr sz rd   le n  rdata         mem addr          be       wdata         we cd data          le fault
        vecs[0]  = '{32'h0000_1234, 32'h0,        0, 0, 0, 4'd3, 1, 0, 32'h0,        0, 32'h0,       4'h0,    32'h0,        0, 1, 32'h0000_1234, 1, 0};
        vecs[1]  = '{32'h0000_0100, 32'h0,        1, 0, 0, 4'd5, 1, 3, 32'hDEAD_BEEF, 1, 32'h0000_0100, 4'b1111, 32'h0,      0, 1, 32'hDEAD_BEEF, 1, 0};
        vecs[2]  = '{32'h0000_0203, 32'h0000_00A5, 0, 1, 1, 4'd6, 1, 1, 32'h0,        1, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 1, 0, 32'h0,   0, 0};
        vecs[3]  = '{32'h0000_0102, 32'h0,        1, 0, 1, 4'd7, 1, 2, 32'h1122_3344, 1, 32'h0000_0100, 4'b0100, 32'h0,      0, 1, 32'h0000_0022, 1, 0};
        vecs[4]  = '{32'h0000_0102, 32'h0,        1, 0, 0, 4'd8, 1, 0, 32'h0,        0, 32'h0,       4'h0,    32'h0,        0, 0, 32'h0,         0, 1};
        vecs[5]  = '{32'h0000_0300, 32'hCAFE_F00D, 0, 1, 0, 4'd9, 0, 1, 32'h0,       1, 32'h0000_0300, 4'b1111, 32'hCAFE_F00D, 1, 0, 32'h0,   0, 0};
        vecs[6]  = '{32'h0000_0040, 32'h1357_9BDF, 1, 1, 0, 4'd10, 1, 1, 32'h55AA_55AA, 1, 32'h0000_0040, 4'b1111, 32'h0,    0, 1, 32'h55AA_55AA, 1, 0};
        vecs[7]  = '{32'h0000_0003, 32'h0,        1, 0, 1, 4'd11, 1, 1, 32'h80FF_0102, 1, 32'h0000_0000, 4'b1000, 32'h0,     0, 1, 32'h0000_0080, 1, 0};
        vecs[8]  = '{32'h0000_0000, 32'h0,        1, 0, 1, 4'd12, 1, 4, 32'h1234_56F0, 1, 32'h0000_0000, 4'b0001, 32'h0,     0, 1, 32'h0000_00F0, 1, 0};
        vecs[9]  = '{32'hFFFF_FFFF, 32'h0,        0, 0, 0, 4'd15, 0, 0, 32'h0,        0, 32'h0,       4'h0,    32'h0,        0, 1, 32'hFFFF_FFFF, 0, 0};
        vecs[10] = '{32'h0000_0301, 32'h0BAD_0BAD, 0, 1, 0, 4'd1, 1, 0, 32'h0,       0, 32'h0,       4'h0,    32'h0,        0, 0, 32'h0,         0, 1};

        idle_inputs();
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_rf_le", wb_rf_le, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_fwd", forward_ex_mem, 0);
        chk("rst_fault", align_fault, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_req", dmem_bus.dmem_req, 0);

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], i);
        end

        // Bubble captured after the last vector must leave WB invalid.
        @(negedge clk);
        chk("bubble_wb_valid", wb_valid, 0);
        chk("bubble_fault", align_fault, 0);

        // Stray ack while idle is ignored.
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = 32'hFFFF_0000;
        #1;
        chk("idle_ack_stall", mem_stall, 0);
        chk("idle_ack_req", dmem_bus.dmem_req, 0);
        @(negedge clk);
        dmem_bus.dmem_ack = 1'b0;
        chk("idle_ack_wbv", wb_valid, 0);

        // Misaligned load, then aligned load acked in its first cycle, then ALU op back-to-back.
        drive_ex(32'h0000_0102, 32'h0, 1, 0, 0, 4'd4, 1);
        @(negedge clk);
        chk("b2b_mis_noreq", dmem_bus.dmem_req, 0);
        drive_ex(32'h0000_0080, 32'h0, 1, 0, 0, 4'd2, 1);
        @(negedge clk);
        chk("b2b_fault", align_fault, 1);
        chk("b2b_mis_wbv", wb_valid, 1);
        chk("b2b_mis_rf_le", wb_rf_le, 0);
        chk("b2b_ld_req", dmem_bus.dmem_req, 1);
        chk("b2b_ld_addr", dmem_bus.dmem_addr, 32'h80);
        drive_ex(32'h0000_0077, 32'h0, 0, 0, 0, 4'd7, 1);
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = 32'h0000_0099;
        #1;
        chk("b2b_ack_stall", mem_stall, 0);
        @(negedge clk);
        dmem_bus.dmem_ack = 1'b0;
        ex_valid = 1'b0;
        chk("b2b_ld_wbv", wb_valid, 1);
        chk("b2b_ld_data", wb_data, 32'h99);
        chk("b2b_ld_rd", wb_rd, 2);
        chk("b2b_fault_pulse", align_fault, 0);
        chk("b2b_alu_fwd", forward_ex_mem, 32'h77);
        chk("b2b_alu_noreq", dmem_bus.dmem_req, 0);
        @(negedge clk);
        chk("b2b_alu_wbv", wb_valid, 1);
        chk("b2b_alu_data", wb_data, 32'h77);
        chk("b2b_alu_rd", wb_rd, 7);
        chk("b2b_alu_rf_le", wb_rf_le, 1);

        // Reset in the middle of an access, followed by a late ack.
        drive_ex(32'h0000_0100, 32'h0, 1, 0, 0, 4'd5, 1);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("rsta_req_before", dmem_bus.dmem_req, 1);
        chk("rsta_stall_before", mem_stall, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rsta_req", dmem_bus.dmem_req, 0);
        chk("rsta_stall", mem_stall, 0);
        chk("rsta_wbv", wb_valid, 0);
        chk("rsta_fwd", forward_ex_mem, 0);
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = 32'hAAAA_5555;
        #1;
        chk("rsta_late_ack_stall", mem_stall, 0);
        @(negedge clk);
        dmem_bus.dmem_ack = 1'b0;
        chk("rsta_late_ack_wbv", wb_valid, 0);
        chk("rsta_late_ack_req", dmem_bus.dmem_req, 0);
        chk("rsta_late_ack_data", wb_data, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
